// File: rtl/pattern_broadcaster_pkg.sv
// Shared types and constants for the DFT pattern broadcaster.
package pattern_broadcaster_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic MODE_BCAST  = 1'b0;
  localparam logic MODE_SERIAL = 1'b1;

endpackage

// File: rtl/pattern_broadcaster_if.sv
// Tester-pin side and adder side signals of the pattern broadcaster.
interface pattern_broadcaster_if #(
  parameter int N  = 16,
  parameter int CH = 2
) ();

  logic            mode;
  logic            start;
  logic [CH-1:0]   pin;
  logic            pin_cin;
  logic [CH*N-1:0] vec;
  logic            cin;
  logic            busy;
  logic            valid;

  modport master (
    output mode, start, pin, pin_cin,
    input  vec, cin, busy, valid
  );

  modport slave (
    input  mode, start, pin, pin_cin,
    output vec, cin, busy, valid
  );

endinterface

// File: rtl/bc_shift_lane.sv
// One channel's shadow register: LSB-first serial input entering at the MSB.
module bc_shift_lane #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [N-1:0] shadow
);

  logic [N-1:0] shadow_q;
  logic [N-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (shift_en) begin
      shadow_d = {bit_in, shadow_q[N-1:1]};
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= {N{1'b0}};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/pattern_broadcaster.sv
// DFT pattern source: per-pin broadcast or atomic serial load of CH operand vectors.
module pattern_broadcaster
  import pattern_broadcaster_pkg::*;
#(
  parameter int N  = 16,
  parameter int CH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pattern_broadcaster_if.slave bus
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CH*N-1:0] vec_q, vec_d;
  logic            cin_q, cin_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            shift_en_s;

  logic [N-1:0]    shadow_s [CH];
  logic [CH*N-1:0] shadow_next_s;
  logic [CH*N-1:0] bcast_s;
  logic [CH-1:0]   unused_lsb_s;

  // The completed pattern includes the bit being shifted this cycle, so it is
  // taken from the lane's next value rather than its registered contents.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    bc_shift_lane #(.N(N)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en_s),
      .bit_in   (bus.pin[c]),
      .shadow   (shadow_s[c])
    );
    assign shadow_next_s[c*N +: N] = {bus.pin[c], shadow_s[c][N-1:1]};
    assign bcast_s[c*N +: N]       = {N{bus.pin[c]}};
    assign unused_lsb_s[c]         = shadow_s[c][0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    cin_d      = cin_q;
    valid_d    = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mode == MODE_BCAST) begin
          vec_d   = bcast_s;
          cin_d   = bus.pin_cin;
          valid_d = 1'b1;
        end else if (bus.start) begin
          state_d    = SHIFT;
          cnt_d      = CW'(1);
          shift_en_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q >= LAST) begin
          vec_d   = shadow_next_s;
          cin_d   = bus.pin_cin;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      vec_q   <= {(CH*N){1'b0}};
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.vec   = vec_q;
  assign bus.cin   = cin_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_pattern_broadcaster.sv
// Self-checking bench: broadcast vector table plus scoreboarded serial-load sequences.
module tb_pattern_broadcaster;
  import pattern_broadcaster_pkg::*;

  localparam int N  = 16;
  localparam int CH = 2;
  localparam int W  = N * CH;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pattern_broadcaster_if #(.N(N), .CH(CH)) bus ();

  pattern_broadcaster #(.N(N), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] vec;
    logic         cin;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [CH-1:0] pin;
    logic          pin_cin;
    logic [W-1:0]  vec;
    logic          cin;
  } bvec_t;

  exp_t         sb_q[$];
  bvec_t        tbl[6];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [W-1:0] held_vec = '0;
  logic         held_cin = 1'b0;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock: outputs sampled on the falling edge; any valid is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("valid_cycle", W'(cyc), W'(e.cyc));
        check("vec", bus.vec, e.vec);
        check("cin", W'(bus.cin), W'(e.cin));
        held_vec = e.vec;
        held_cin = e.cin;
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_valid: got valid=0 expected valid=1 (cycle %0d)", cyc);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic serial_load(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic cin_last, input bit disturb);
    sb_q.push_back('{{b, a}, cin_last, cyc + N});
    for (int i = 0; i < N; i++) begin
      bus.mode    = (disturb && i > 0) ? logic'(i[0]) : MODE_SERIAL;
      bus.start   = (i == 0) ? 1'b1 : (disturb ? logic'(i[1]) : 1'b0);
      bus.pin     = {b[i], a[i]};
      bus.pin_cin = (i == N - 1) ? cin_last : ~cin_last;
      tick();
      if (i < N - 1) begin
        check("shift_busy", W'(bus.busy), W'(1));
        check("shift_hold_vec", bus.vec, held_vec);
        check("shift_hold_cin", W'(bus.cin), W'(held_cin));
      end else begin
        check("done_busy", W'(bus.busy), W'(0));
      end
    end
    bus.mode  = MODE_SERIAL;
    bus.start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'b01, 1'b1, 32'h0000_FFFF, 1'b1};
    tbl[1] = '{2'b10, 1'b0, 32'hFFFF_0000, 1'b0};
    tbl[2] = '{2'b11, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[3] = '{2'b00, 1'b0, 32'h0000_0000, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 32'hFFFF_0000, 1'b1};
    tbl[5] = '{2'b01, 1'b0, 32'h0000_FFFF, 1'b0};

    rst_n       = 1'b0;
    bus.mode    = MODE_BCAST;
    bus.start   = 1'b0;
    bus.pin     = '0;
    bus.pin_cin = 1'b0;
    #1;
    check("reset_vec", bus.vec, W'(0));
    check("reset_cin", W'(bus.cin), W'(0));
    check("reset_busy", W'(bus.busy), W'(0));
    check("reset_valid", W'(bus.valid), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      bus.mode    = MODE_BCAST;
      bus.pin     = tbl[i].pin;
      bus.pin_cin = tbl[i].pin_cin;
      sb_q.push_back('{tbl[i].vec, tbl[i].cin, cyc + 1});
      tick();
      check("bcast_busy", W'(bus.busy), W'(0));
    end

    bus.mode = MODE_SERIAL;
    bus.pin  = 2'b11;
    tick();
    check("idle_hold_vec", bus.vec, held_vec);

    serial_load(16'hA5C3, 16'h1234, 1'b1, 1'b0);
    serial_load(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    serial_load(16'h3C96, 16'hE00F, 1'b1, 1'b1);
    tick();
    check("post_load_hold", bus.vec, held_vec);

    bus.mode  = MODE_SERIAL;
    bus.start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.pin = i[1:0];
      tick();
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midload_rst_vec", bus.vec, W'(0));
    check("midload_rst_cin", W'(bus.cin), W'(0));
    check("midload_rst_busy", W'(bus.busy), W'(0));
    check("midload_rst_valid", W'(bus.valid), W'(0));
    sb_q.delete();
    held_vec = '0;
    held_cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_busy", W'(bus.busy), W'(0));
    serial_load(16'h8001, 16'h7FFE, 1'b0, 1'b0);

    for (int i = 4; i < 6; i++) begin
      bus.mode    = MODE_BCAST;
      bus.pin     = tbl[i].pin;
      bus.pin_cin = tbl[i].pin_cin;
      sb_q.push_back('{tbl[i].vec, tbl[i].cin, cyc + 1});
      tick();
    end

    check("sb_drained", W'(sb_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
